// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver with majority-vote bit
// decisions, false-start rejection, framing/overrun flags and a byte FIFO.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   RxD       serial line, idles high, asynchronous to clk
//   rd_en     pop the head byte (ignored while empty)
//   clr_err   clear the sticky frame_err / overrun flags
//   dout      head-of-FIFO byte, first-word fall-through (0 while empty)
//   empty     FIFO holds no bytes
//   full      FIFO holds DEPTH bytes
//   frame_err sticky: a stop bit was sampled low
//   overrun   sticky: a valid byte arrived while full
//   busy      a frame is being received
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_fifo: CLK_FREQ / (BAUD*16) must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] tcnt;
    logic          tick;
    logic          start_go;

    state_t        state;
    state_t        state_d;
    logic [3:0]    sc;
    logic [3:0]    sc_d;
    logic [2:0]    bitn;
    logic [2:0]    bitn_d;
    logic [7:0]    shreg;
    logic [7:0]    shreg_d;
    logic          s7;
    logic          s8;
    logic          maj;
    logic          push;
    logic          ferr_set;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic          ovr_set;

    // Two-flop synchronizer; both stages reset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    // Free-running 16x tick; realigned to the start-detect tick.
    assign tick     = (tcnt == CW'(DIV - 1));
    assign start_go = (state == S_IDLE) && (state_d == S_START);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick || start_go) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + CW'(1);
        end
    end

    // Samples 7 and 8 are held; sample 9 is the live rxs at decision time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick && state != S_IDLE) begin
            if (sc == 4'd7) s7 <= rxs;
            if (sc == 4'd8) s8 <= rxs;
        end
    end

    assign maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sc    <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            sc    <= sc_d;
            bitn  <= bitn_d;
            shreg <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state;
        sc_d     = sc;
        bitn_d   = bitn;
        shreg_d  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (tick) begin
            unique case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        sc_d    = '0;
                    end
                end
                S_START: begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd9 && maj) begin
                        state_d = S_IDLE;
                        sc_d    = '0;
                    end else if (sc == 4'd15) begin
                        state_d = S_DATA;
                        bitn_d  = '0;
                    end
                end
                S_DATA: begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd9) begin
                        shreg_d = {maj, shreg[7:1]};
                    end
                    if (sc == 4'd15) begin
                        bitn_d = bitn + 3'd1;
                        if (bitn == 3'd7) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd9) begin
                        sc_d = '0;
                        if (maj) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign ovr_set = push && full;
    assign do_pop  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign dout = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Sticky flags: a set event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

endmodule
